// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port and the load/store data port. Each access is a
// one-cycle m_en strobe followed by a fixed-latency response, returned to the
// winning requester as a one-cycle ready pulse.

module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    // Instruction-fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_kill,
    output logic [31:0] i_rdata,
    output logic        i_ready,

    // Load/store data port
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    input  logic        d_wen,
    output logic [31:0] d_rdata,
    output logic        d_ready,

    // Memory side
    output logic        m_en,
    output logic        m_wen,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wmask,
    input  logic [31:0] m_rdata,

    output logic        busy
);

    typedef enum logic {StIdle, StWait} state_e;
    typedef enum logic {OwnFetch, OwnData} owner_e;

    localparam logic [3:0] LatInit   = 4'(MEM_LATENCY);
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e     state_q;
    owner_e     owner_q;
    logic [3:0] lat_cnt_q;
    logic [3:0] starve_cnt_q;
    logic       killed_q;

    logic       can_issue;
    logic       starved;
    logic       grant_data;
    logic       grant_fetch;
    logic       last_cycle;

    // Arbitration: data wins unless a waiting fetch has hit the starvation limit.
    // Reset gates the grant so the memory strobe is quiet while reset is held.
    always_comb begin
        can_issue   = (state_q == StIdle) && !reset;
        starved     = (starve_cnt_q == StarveMax);
        grant_data  = can_issue && d_req && !(i_req && starved);
        grant_fetch = can_issue && i_req && !grant_data;
    end

    // Memory-side mux: only the winner's fields reach the memory, otherwise all zero.
    always_comb begin
        m_en    = 1'b0;
        m_wen   = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wmask = '0;
        if (grant_data) begin
            m_en    = 1'b1;
            m_wen   = d_wen;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_wmask = d_wmask;
        end else if (grant_fetch) begin
            m_en    = 1'b1;
            m_addr  = i_addr;
        end
    end

    // Ready pulses in the final wait cycle; a same-cycle kill still drops the fetch.
    always_comb begin
        last_cycle = (state_q == StWait) && (lat_cnt_q == 4'd1);
        i_ready    = last_cycle && (owner_q == OwnFetch) && !killed_q && !i_kill;
        d_ready    = last_cycle && (owner_q == OwnData);
        busy       = (state_q == StWait);
        i_rdata    = m_rdata;
        d_rdata    = m_rdata;
    end

    // Sequencer: issue in IDLE, count down the memory latency in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= OwnFetch;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            killed_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_data || grant_fetch) begin
                        state_q   <= StWait;
                        owner_q   <= grant_data ? OwnData : OwnFetch;
                        lat_cnt_q <= LatInit;
                        killed_q  <= 1'b0;
                        // Only a data grant that bypasses a waiting fetch counts.
                        if (grant_data && i_req) begin
                            if (starve_cnt_q < StarveMax) begin
                                starve_cnt_q <= starve_cnt_q + 4'd1;
                            end
                        end else begin
                            starve_cnt_q <= '0;
                        end
                    end else begin
                        starve_cnt_q <= '0;
                    end
                end
                StWait: begin
                    lat_cnt_q <= lat_cnt_q - 4'd1;
                    if ((owner_q == OwnFetch) && i_kill) begin
                        killed_q <= 1'b1;
                    end
                    if (lat_cnt_q == 4'd1) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a fixed-latency memory model answers m_en
// strobes; expected responses are queued per port when requests are driven
// and popped when the matching ready pulse appears.

module tb_mem_port_arbiter;

    localparam int unsigned LAT    = 3;
    localparam int unsigned STARVE = 4;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_kill;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        d_wen;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_en;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic [31:0] m_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t        iq[$];
    exp_t        dq[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] rd_pipe [LAT];

    mem_port_arbiter #(
        .MEM_LATENCY (LAT),
        .STARVE_LIMIT(STARVE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_kill (i_kill),
        .i_rdata(i_rdata),
        .i_ready(i_ready),
        .d_req  (d_req),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_wmask(d_wmask),
        .d_wen  (d_wen),
        .d_rdata(d_rdata),
        .d_ready(d_ready),
        .m_en   (m_en),
        .m_wen  (m_wen),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_wmask(m_wmask),
        .m_rdata(m_rdata),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic void push_i(input logic chk, input logic [31:0] data);
        exp_t e;
        e.chk  = chk;
        e.data = data;
        iq.push_back(e);
    endfunction

    function automatic void push_d(input logic chk, input logic [31:0] data);
        exp_t e;
        e.chk  = chk;
        e.data = data;
        dq.push_back(e);
    endfunction

    // Memory model: read (then optional masked write) at m_en, data after LAT cycles.
    assign m_rdata = rd_pipe[LAT-1];
    initial for (int k = 0; k < LAT; k++) rd_pipe[k] = 32'h0BAD_F00D;
    always @(posedge clk) begin : env_model
        logic [31:0] rd;
        for (int k = LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
        if (m_en) begin
            rd = env_mem.exists(m_addr) ? env_mem[m_addr] : init_word(m_addr);
            if (m_wen) env_mem[m_addr] = merge(rd, m_wdata, m_wmask);
            rd_pipe[0] <= rd;
        end else begin
            rd_pipe[0] <= 32'h0BAD_F00D;
        end
    end

    // Scoreboard: every ready pulse must match a queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (i_ready && d_ready) begin
                checks++;
                errors++;
                $display("FAIL both_ready: i_ready=%b d_ready=%b want one at most", i_ready,
                         d_ready);
            end
            if (i_ready) begin
                exp_t e;
                checks++;
                if (iq.size() == 0) begin
                    errors++;
                    $display("FAIL i_ready_unexpected: got i_ready=1 want 0 at %0t", $time);
                end else begin
                    e = iq.pop_front();
                    if (e.chk && (i_rdata !== e.data)) begin
                        errors++;
                        $display("FAIL i_rdata: got %h want %h", i_rdata, e.data);
                    end
                end
            end
            if (d_ready) begin
                exp_t e;
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL d_ready_unexpected: got d_ready=1 want 0 at %0t", $time);
                end else begin
                    e = dq.pop_front();
                    if (e.chk && (d_rdata !== e.data)) begin
                        errors++;
                        $display("FAIL d_rdata: got %h want %h", d_rdata, e.data);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Waits (bounded) for a ready pulse; returns at the negedge of the ready cycle.
    task automatic wait_ready(input bit is_data, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            sample();
            if (is_data ? d_ready : i_ready) ok = 1'b1;
            else next_cycle();
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        i_req  = 1'b1;
        i_addr = 32'h10;
        d_req  = 1'b1;
        d_addr = 32'h20;
        sample();
        checks++;
        if ({m_en, m_wen, busy, i_ready, d_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {m_en, m_wen, busy, i_ready, d_ready});
        end
        checks++;
        if ({m_addr, m_wdata, m_wmask} !== 68'h0) begin
            errors++;
            $display("FAIL reset_mbus: got %h want 0", {m_addr, m_wdata, m_wmask});
        end
        checks++;
        if ((i_rdata !== m_rdata) || (d_rdata !== m_rdata)) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h want %h", i_rdata, d_rdata, m_rdata);
        end
        next_cycle();
        i_req = 1'b0;
        d_req = 1'b0;
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_fetch();
        bit ok;
        i_req  = 1'b1;
        i_addr = 32'h100;
        push_i(1'b1, ref_read(32'h100));
        sample();
        checks++;
        if ({m_en, m_wen, m_addr, m_wdata, m_wmask} !== {2'b10, 32'h100, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL fetch_issue: got en=%b wen=%b addr=%h wd=%h wm=%h want 1 0 100 0 0",
                     m_en, m_wen, m_addr, m_wdata, m_wmask);
        end
        for (int c = 1; c <= LAT; c++) begin
            logic [2:0] want;
            next_cycle();
            sample();
            want = (c == LAT) ? 3'b110 : 3'b010;
            checks++;
            if ({i_ready, busy, m_en} !== want) begin
                errors++;
                $display("FAIL fetch_wait c%0d: got rdy/busy/en=%b want %b", c,
                         {i_ready, busy, m_en}, want);
            end
        end
        next_cycle();
        i_addr = 32'h104;
        push_i(1'b1, ref_read(32'h104));
        sample();
        checks++;
        if ({m_en, m_addr} !== {1'b1, 32'h104}) begin
            errors++;
            $display("FAIL fetch_next_issue: got en=%b addr=%h want 1 104", m_en, m_addr);
        end
        wait_ready(1'b0, LAT + 3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fetch_second_ready: got timeout want i_ready");
        end
        next_cycle();
        i_req = 1'b0;
    endtask

    task automatic test_store();
        bit ok;
        d_req   = 1'b1;
        d_wen   = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'hDEADBEEF;
        d_wmask = 4'h3;
        ref_mem[32'h40] = merge(ref_read(32'h40), 32'hDEADBEEF, 4'h3);
        push_d(1'b0, 32'h0);
        sample();
        checks++;
        if ({m_en, m_wen, m_wmask, m_wdata, m_addr} !== {2'b11, 4'h3, 32'hDEADBEEF, 32'h40})
        begin
            errors++;
            $display("FAIL store_issue: got en=%b wen=%b wm=%h wd=%h addr=%h want 1 1 3 deadbeef 40",
                     m_en, m_wen, m_wmask, m_wdata, m_addr);
        end
        for (int c = 1; c <= LAT; c++) begin
            logic [2:0] want;
            next_cycle();
            sample();
            want = (c == LAT) ? 3'b001 : 3'b000;
            checks++;
            if ({m_en, m_wen, d_ready} !== want) begin
                errors++;
                $display("FAIL store_wait c%0d: got en/wen/rdy=%b want %b", c,
                         {m_en, m_wen, d_ready}, want);
            end
        end
        // Load back the merged word.
        next_cycle();
        d_wen = 1'b0;
        push_d(1'b1, ref_read(32'h40));
        sample();
        checks++;
        if ({m_en, m_wen, m_addr} !== {2'b10, 32'h40}) begin
            errors++;
            $display("FAIL load_issue: got en=%b wen=%b addr=%h want 1 0 40", m_en, m_wen,
                     m_addr);
        end
        wait_ready(1'b1, LAT + 3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL load_ready: got timeout want d_ready");
        end
        next_cycle();
        d_req = 1'b0;
    endtask

    task automatic test_starvation();
        string exp_order;
        int    grants;
        bit    done;
        byte   g;
        exp_order = "DDDDFDDDDF";
        grants    = 0;
        done      = 1'b0;
        i_req     = 1'b1;
        i_addr    = 32'h200;
        d_req     = 1'b1;
        d_wen     = 1'b0;
        d_addr    = 32'h300;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            sample();
            if (m_en) begin
                g = (m_addr == 32'h300) ? "D" : ((m_addr == 32'h200) ? "F" : "?");
                if (g == "D") push_d(1'b1, ref_read(32'h300));
                else push_i(1'b1, ref_read(32'h200));
                if (grants < 10) begin
                    checks++;
                    if (g != exp_order[grants]) begin
                        errors++;
                        $display("FAIL starve_grant%0d: got %c want %c", grants, g,
                                 exp_order[grants]);
                    end
                end
                grants++;
            end
            if (grants == 10 && i_ready) done = 1'b1;
            else next_cycle();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL starve_timeout: got %0d grants want 10 then i_ready", grants);
        end
        next_cycle();
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_kill();
        bit ok;
        i_req  = 1'b1;
        i_addr = 32'h500;
        sample();
        checks++;
        if ({m_en, m_addr} !== {1'b1, 32'h500}) begin
            errors++;
            $display("FAIL kill_issue: got en=%b addr=%h want 1 500", m_en, m_addr);
        end
        for (int c = 1; c <= LAT; c++) begin
            next_cycle();
            if (c == 1) begin
                i_req  = 1'b0;
                i_kill = 1'b1;
                d_req  = 1'b1;
                d_wen  = 1'b0;
                d_addr = 32'h600;
                push_d(1'b1, ref_read(32'h600));
            end else begin
                i_kill = 1'b0;
            end
            sample();
            checks++;
            if ({i_ready, busy, m_en} !== 3'b010) begin
                errors++;
                $display("FAIL kill_wait c%0d: got rdy/busy/en=%b want 010", c,
                         {i_ready, busy, m_en});
            end
        end
        next_cycle();
        sample();
        checks++;
        if ({i_ready, busy, m_en, m_addr} !== {3'b001, 32'h600}) begin
            errors++;
            $display("FAIL kill_data_grant: got rdy=%b busy=%b en=%b addr=%h want 0 0 1 600",
                     i_ready, busy, m_en, m_addr);
        end
        wait_ready(1'b1, LAT + 3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL kill_data_ready: got timeout want d_ready");
        end
        next_cycle();
        d_req = 1'b0;
    endtask

    task automatic test_kill_coincide();
        i_req  = 1'b1;
        i_addr = 32'h700;
        sample();
        for (int c = 1; c <= LAT; c++) begin
            next_cycle();
            if (c == LAT) i_kill = 1'b1;
            sample();
        end
        checks++;
        if ({i_ready, busy} !== 2'b01) begin
            errors++;
            $display("FAIL kill_coincide: got rdy/busy=%b want 01", {i_ready, busy});
        end
        next_cycle();
        i_kill = 1'b0;
        i_req  = 1'b0;
        sample();
        checks++;
        if ({busy, m_en} !== 2'b00) begin
            errors++;
            $display("FAIL kill_coincide_idle: got busy/en=%b want 00", {busy, m_en});
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        d_req  = 1'b1;
        d_wen  = 1'b0;
        d_addr = 32'h800;
        sample();
        checks++;
        if ({m_en, m_addr} !== {1'b1, 32'h800}) begin
            errors++;
            $display("FAIL rst_mid_issue: got en=%b addr=%h want 1 800", m_en, m_addr);
        end
        next_cycle();
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, d_ready, m_en} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_immediate: got busy/rdy/en=%b want 000",
                     {busy, d_ready, m_en});
        end
        next_cycle();
        reset  = 1'b0;
        d_req  = 1'b0;
        i_req  = 1'b1;
        i_addr = 32'h900;
        push_i(1'b1, ref_read(32'h900));
        sample();
        checks++;
        if ({m_en, m_addr, dut.starve_cnt_q} !== {1'b1, 32'h900, 4'h0}) begin
            errors++;
            $display("FAIL rst_mid_regrant: got en=%b addr=%h starve=%0d want 1 900 0", m_en,
                     m_addr, dut.starve_cnt_q);
        end
        wait_ready(1'b0, LAT + 3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_fetch_ready: got timeout want i_ready");
        end
        next_cycle();
        i_req = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        i_kill  = 1'b0;
        d_req   = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_wmask = '0;
        d_wen   = 1'b0;
        #1;
        test_reset();
        test_fetch();
        test_store();
        test_starvation();
        test_kill();
        test_kill_coincide();
        test_reset_mid_wait();
        repeat (LAT + 2) next_cycle();
        checks++;
        if ((iq.size() != 0) || (dq.size() != 0)) begin
            errors++;
            $display("FAIL leftover_expect: got %0d/%0d pending want 0/0", iq.size(),
                     dq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
